// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory bus arbiter.
//   arb_state_t : sequencer states (IDLE, DATA, FETCH, STEP, HALT)
//   ADDR_W      : bus/core address width
//   DATA_W      : bus/core data width
//   BE_W        : byte-enable width
//   BE_WORD     : full-word byte-enable used for instruction fetches
package mem_arb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    localparam logic [BE_W-1:0] BE_WORD = 4'hF;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DATA  = 3'd1,
        FETCH = 3'd2,
        STEP  = 3'd3,
        HALT  = 3'd4
    } arb_state_t;

    // A data phase is needed whenever the core asks for a load or a store.
    function automatic logic is_data_req(input logic rd, input logic wr);
        return rd | wr;
    endfunction

endpackage

// File: rtl/arb_wait_timer.sv
// arb_wait_timer: counts consecutive stalled cycles of one bus transaction.
//   clk       in  : clock
//   reset     in  : synchronous active-high reset
//   clear     in  : restart the count (new transaction starts)
//   count_en  in  : this cycle is a stalled strobe cycle (waitrequest & strobe)
//   expired   out : this stalled cycle is the TIMEOUT_CYCLES-th in a row
module arb_wait_timer #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    // Count value held during the last permitted stalled cycle.
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // Stall counter: clear wins over increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en) begin
            count <= count + CNT_W'(1);
        end else begin
            count <= count;
        end
    end

    // Flag raised combinationally so the FSM leaves on the same edge that
    // would otherwise have counted the TIMEOUT_CYCLES-th stall.
    always_comb begin
        expired = count_en & (count == LAST);
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: lets a single-cycle Harvard core share one word-addressed
// Avalon-style bus with wait-states. Each step: optional data access, one
// instruction fetch, then a single-cycle core clock enable.
//   clk, reset             : clock, synchronous active-high reset
//   enable, cpu_active     : run gates, only honoured in IDLE
//   cpu_instr_address      : fetch address
//   cpu_data_*             : data address/read/write/store data
//   cpu_byte_enable        : data byte lanes
//   cpu_clk_enable     out : one-cycle step pulse to the core
//   cpu_instr_readdata out : registered fetched word
//   cpu_data_readdata  out : registered load word
//   bus_*              out : registered bus request (address/strobes/data/lanes)
//   bus_waitrequest, bus_readdata in : slave response
//   bus_error          out : sticky transaction-timeout flag
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              cpu_active,
    input  logic [ADDR_W-1:0] cpu_instr_address,
    input  logic [ADDR_W-1:0] cpu_data_address,
    input  logic              cpu_data_read,
    input  logic              cpu_data_write,
    input  logic [DATA_W-1:0] cpu_data_writedata,
    input  logic [BE_W-1:0]   cpu_byte_enable,
    output logic              cpu_clk_enable,
    output logic [DATA_W-1:0] cpu_instr_readdata,
    output logic [DATA_W-1:0] cpu_data_readdata,
    output logic [ADDR_W-1:0] bus_address,
    output logic              bus_read,
    output logic              bus_write,
    output logic [DATA_W-1:0] bus_writedata,
    output logic [BE_W-1:0]   bus_byteenable,
    input  logic              bus_waitrequest,
    input  logic [DATA_W-1:0] bus_readdata,
    output logic              bus_error
);

    arb_state_t state;
    arb_state_t next_state;

    logic start_data;
    logic start_fetch;
    logic cap_data;
    logic cap_instr;
    logic step_next;
    logic err_set;
    logic read_next;
    logic write_next;
    logic timer_clear;
    logic count_en;
    logic expired;

    // Timer restarts whenever a new transaction is latched.
    always_comb begin
        timer_clear = start_data | start_fetch;
        count_en    = bus_waitrequest & (bus_read | bus_write);
    end

    arb_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_wait_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (timer_clear),
        .count_en (count_en),
        .expired  (expired)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and next values of the registered strobes/controls.
    always_comb begin
        next_state  = state;
        start_data  = 1'b0;
        start_fetch = 1'b0;
        cap_data    = 1'b0;
        cap_instr   = 1'b0;
        step_next   = 1'b0;
        err_set     = 1'b0;
        read_next   = 1'b0;
        write_next  = 1'b0;
        case (state)
            IDLE: begin
                if (enable && cpu_active) begin
                    if (is_data_req(cpu_data_read, cpu_data_write)) begin
                        next_state = DATA;
                        start_data = 1'b1;
                        // A simultaneous read+write request is served as a write.
                        write_next = cpu_data_write;
                        read_next  = ~cpu_data_write;
                    end else begin
                        next_state  = FETCH;
                        start_fetch = 1'b1;
                        read_next   = 1'b1;
                    end
                end else begin
                    next_state = IDLE;
                end
            end
            DATA: begin
                if (expired) begin
                    next_state = HALT;
                    err_set    = 1'b1;
                end else if (!bus_waitrequest) begin
                    // Data phase done: the fetch read is issued on the same edge.
                    next_state  = FETCH;
                    start_fetch = 1'b1;
                    cap_data    = bus_read;
                    read_next   = 1'b1;
                end else begin
                    read_next  = bus_read;
                    write_next = bus_write;
                end
            end
            FETCH: begin
                if (expired) begin
                    next_state = HALT;
                    err_set    = 1'b1;
                end else if (!bus_waitrequest) begin
                    next_state = STEP;
                    cap_instr  = 1'b1;
                    step_next  = 1'b1;
                end else begin
                    read_next = 1'b1;
                end
            end
            STEP: begin
                next_state = IDLE;
            end
            HALT: begin
                next_state = HALT;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Registered bus request, core step pulse, readdata and error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus_read           <= 1'b0;
            bus_write          <= 1'b0;
            bus_address        <= '0;
            bus_writedata      <= '0;
            bus_byteenable     <= '0;
            cpu_clk_enable     <= 1'b0;
            cpu_instr_readdata <= '0;
            cpu_data_readdata  <= '0;
            bus_error          <= 1'b0;
        end else begin
            bus_read       <= read_next;
            bus_write      <= write_next;
            cpu_clk_enable <= step_next;
            bus_error      <= bus_error | err_set;
            if (start_data) begin
                bus_address    <= cpu_data_address;
                bus_byteenable <= cpu_byte_enable;
                bus_writedata  <= cpu_data_writedata;
            end else if (start_fetch) begin
                bus_address    <= cpu_instr_address;
                bus_byteenable <= BE_WORD;
            end
            if (cap_data) begin
                cpu_data_readdata <= bus_readdata;
            end
            if (cap_instr) begin
                cpu_instr_readdata <= bus_readdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        cpu_active;
    logic [31:0] cpu_instr_address;
    logic [31:0] cpu_data_address;
    logic        cpu_data_read;
    logic        cpu_data_write;
    logic [31:0] cpu_data_writedata;
    logic [3:0]  cpu_byte_enable;
    logic        cpu_clk_enable;
    logic [31:0] cpu_instr_readdata;
    logic [31:0] cpu_data_readdata;
    logic [31:0] bus_address;
    logic        bus_read;
    logic        bus_write;
    logic [31:0] bus_writedata;
    logic [3:0]  bus_byteenable;
    logic        bus_waitrequest;
    logic [31:0] bus_readdata;
    logic        bus_error;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } txn_t;

    txn_t        exp_q[$];
    int          n_vectors     = 0;
    int          n_miscompares = 0;
    int          wait_data     = 0;
    int          wait_fetch    = 0;
    logic        stuck         = 1'b0;
    int          seen          = 0;
    logic [31:0] exp_data_rd   = 32'd0;
    logic        is_fetch;

    mem_bus_arbiter #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
        .clk                (clk),
        .reset              (reset),
        .enable             (enable),
        .cpu_active         (cpu_active),
        .cpu_instr_address  (cpu_instr_address),
        .cpu_data_address   (cpu_data_address),
        .cpu_data_read      (cpu_data_read),
        .cpu_data_write     (cpu_data_write),
        .cpu_data_writedata (cpu_data_writedata),
        .cpu_byte_enable    (cpu_byte_enable),
        .cpu_clk_enable     (cpu_clk_enable),
        .cpu_instr_readdata (cpu_instr_readdata),
        .cpu_data_readdata  (cpu_data_readdata),
        .bus_address        (bus_address),
        .bus_read           (bus_read),
        .bus_write          (bus_write),
        .bus_writedata      (bus_writedata),
        .bus_byteenable     (bus_byteenable),
        .bus_waitrequest    (bus_waitrequest),
        .bus_readdata       (bus_readdata),
        .bus_error          (bus_error)
    );

    always #5 clk = ~clk;

    // Slave memory contents.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'hBFC0_0000: return 32'h2402_0005;
            32'h0000_1000: return 32'hDEAD_BEEF;
            default:       return a ^ 32'hA5A5_5A5A;
        endcase
    endfunction

    // Slave: inserts a configurable number of wait-states per transaction.
    assign is_fetch        = bus_read && (bus_address == cpu_instr_address);
    assign bus_readdata    = mem_word(bus_address);
    assign bus_waitrequest = stuck | ((bus_read | bus_write) &&
                             (seen < (is_fetch ? wait_fetch : wait_data)));

    always @(posedge clk) begin
        if (!(bus_read || bus_write) || !bus_waitrequest) seen <= 0;
        else seen <= seen + 1;
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vectors++;
        if (obs !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every completed bus transaction is popped and compared.
    always @(negedge clk) begin
        if (!reset && (bus_read || bus_write) && !bus_waitrequest) begin
            check_value("rw_excl", {31'd0, bus_read & bus_write}, 32'd0);
            if (exp_q.size() == 0) begin
                check_value("txn_expected", 32'(exp_q.size()), 32'd1);
            end else begin
                txn_t t;
                t = exp_q.pop_front();
                check_value("txn_write", {31'd0, bus_write}, {31'd0, t.wr});
                check_value("txn_addr", bus_address, t.addr);
                check_value("txn_be", {28'd0, bus_byteenable}, {28'd0, t.be});
                if (t.wr) check_value("txn_wdata", bus_writedata, t.wdata);
            end
        end
    end

    // One core step, started at the falling edge of an IDLE cycle.
    task automatic do_step(input logic rd, input logic wr, input logic [31:0] iaddr,
                           input logic [31:0] daddr, input logic [31:0] wdata,
                           input logic [3:0] be, input int wd, input int wf);
        txn_t t;
        int   cyc;
        int   exp_cyc;
        logic got_en;
        cpu_instr_address  = iaddr;
        cpu_data_address   = daddr;
        cpu_data_read      = rd;
        cpu_data_write     = wr;
        cpu_data_writedata = wdata;
        cpu_byte_enable    = be;
        wait_data          = wd;
        wait_fetch         = wf;
        enable             = 1'b1;
        cpu_active         = 1'b1;
        exp_cyc            = 3 + wf;
        if (rd || wr) begin
            t = '{wr, daddr, be, wdata};
            exp_q.push_back(t);
            exp_cyc = exp_cyc + 1 + wd;
            if (!wr) exp_data_rd = mem_word(daddr);
        end
        t = '{1'b0, iaddr, 4'hF, 32'd0};
        exp_q.push_back(t);
        cyc    = 1;
        got_en = 1'b0;
        while (!got_en && cyc < 100) begin
            @(negedge clk);
            cyc++;
            got_en = cpu_clk_enable;
        end
        check_value("step_seen", {31'd0, got_en}, 32'd1);
        check_value("step_cycles", 32'(cyc), 32'(exp_cyc));
        check_value("instr_rd", cpu_instr_readdata, mem_word(iaddr));
        check_value("data_rd", cpu_data_readdata, exp_data_rd);
        check_value("txn_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(negedge clk);
        enable = 1'b0;
        check_value("step_pulse_low", {31'd0, cpu_clk_enable}, 32'd0);
    endtask

    task automatic gate_check(input logic en, input logic act, input string tag);
        int strobes;
        int pulses;
        enable         = en;
        cpu_active     = act;
        cpu_data_read  = 1'b1;
        cpu_data_write = 1'b0;
        strobes        = 0;
        pulses         = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus_read || bus_write) strobes++;
            if (cpu_clk_enable) pulses++;
        end
        check_value(tag, 32'(strobes + pulses), 32'd0);
        enable = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   rd_cyc;
        int   en_cyc;
        logic prev_rd;
        reset              = 1'b1;
        enable             = 1'b0;
        cpu_active         = 1'b0;
        cpu_instr_address  = 32'd0;
        cpu_data_address   = 32'd0;
        cpu_data_read      = 1'b0;
        cpu_data_write     = 1'b0;
        cpu_data_writedata = 32'd0;
        cpu_byte_enable    = 4'd0;
        repeat (3) @(negedge clk);
        check_value("rst_strobes", {30'd0, bus_read, bus_write}, 32'd0);
        check_value("rst_addr", bus_address, 32'd0);
        check_value("rst_wdata_be", bus_writedata | {28'd0, bus_byteenable}, 32'd0);
        check_value("rst_readdata", cpu_instr_readdata | cpu_data_readdata, 32'd0);
        check_value("rst_en_err", {30'd0, cpu_clk_enable, bus_error}, 32'd0);
        reset = 1'b0;

        // Pure fetch, load with 2 waits, store, read+write, waited fetch, load.
        do_step(1'b0, 1'b0, 32'hBFC0_0000, 32'h0,         32'h0,         4'hF,    0, 0);
        do_step(1'b1, 1'b0, 32'hBFC0_0004, 32'h0000_1000, 32'h0,         4'hF,    2, 0);
        do_step(1'b0, 1'b1, 32'hBFC0_0008, 32'h0000_2000, 32'h1234_5678, 4'b0011, 0, 0);
        do_step(1'b1, 1'b1, 32'hBFC0_000C, 32'h0000_3000, 32'hCAFE_F00D, 4'b1100, 1, 1);
        do_step(1'b0, 1'b0, 32'hBFC0_0010, 32'h0,         32'h0,         4'hF,    0, 3);
        do_step(1'b1, 1'b0, 32'hBFC0_0014, 32'h0000_4000, 32'h0,         4'hF,    0, 1);

        gate_check(1'b1, 1'b0, "gate_inactive");
        gate_check(1'b0, 1'b1, "gate_disabled");

        // Timeout: waitrequest stuck high during a fetch.
        stuck             = 1'b1;
        cpu_instr_address = 32'hBFC0_0018;
        cpu_data_read     = 1'b0;
        cpu_data_write    = 1'b0;
        enable            = 1'b1;
        cpu_active        = 1'b1;
        rd_cyc            = 0;
        en_cyc            = 0;
        prev_rd           = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus_read) rd_cyc++;
            if (cpu_clk_enable || bus_write) en_cyc++;
            if (bus_read && !prev_rd) check_value("err_before", {31'd0, bus_error}, 32'd0);
            if (prev_rd && !bus_read) check_value("err_at_drop", {31'd0, bus_error}, 32'd1);
            prev_rd = bus_read;
        end
        check_value("timeout_strobe_cycles", 32'(rd_cyc), 32'd4);
        check_value("halt_no_activity", 32'(en_cyc), 32'd0);
        check_value("halt_error", {31'd0, bus_error}, 32'd1);
        stuck  = 1'b0;
        enable = 1'b0;
        reset  = 1'b1;
        @(negedge clk);
        reset       = 1'b0;
        exp_data_rd = 32'd0;
        check_value("rst_clears_err", {31'd0, bus_error}, 32'd0);

        // Reset in the middle of a waited data read.
        do_step(1'b1, 1'b0, 32'hBFC0_0000, 32'h0000_1000, 32'h0, 4'hF, 0, 0);
        cpu_data_read    = 1'b1;
        cpu_data_address = 32'h0000_5000;
        wait_data        = 10;
        enable           = 1'b1;
        repeat (2) @(negedge clk);
        check_value("mid_read", {31'd0, bus_read}, 32'd1);
        reset  = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        check_value("midrst_strobes", {30'd0, bus_read, bus_write}, 32'd0);
        check_value("midrst_readdata", cpu_instr_readdata | cpu_data_readdata, 32'd0);
        reset       = 1'b0;
        exp_data_rd = 32'd0;
        exp_q.delete();
        do_step(1'b0, 1'b0, 32'hBFC0_0020, 32'h0, 32'h0, 4'hF, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
